rr_stream_mux: RTL and testbench

- Parametrised N-to-1 streaming multiplexer with valid/ready handshakes and a registered output stage. It is the sequential successor of the 2:1 datapath mux.
- Arbitrates between N producer channels using round-robin or fixed priority. Optional packet lock holds the grant until a last-flagged beat.
- Sits between multi-source datapath producers (e.g. writeback/memory-response sources) and a single consumer.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/rr_stream_mux.sv | 128 ++++++++++++
 tb/tb_rr_stream_mux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, lock states and index-width helper for rr_stream_mux
package mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // A two-channel mux still needs one select bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant from round-robin or fixed priority, with lock override
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = MODE_RR,
  parameter int SW   = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          lock_en,
  input  logic [SW-1:0] lock_idx,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  // Searching downward and overwriting leaves the first hit of an upward search.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (lock_en) begin
      grant[lock_idx] = 1'b1;
      grant_idx       = lock_idx;
    end else if (MODE == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req[(int'(ptr) + k) % N]) begin
          grant                        = '0;
          grant[(int'(ptr) + k) % N]   = 1'b1;
          grant_idx                    = SW'((int'(ptr) + k) % N);
        end
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-to-1 valid/ready stream mux with registered output and optional packet lock
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int MODE = MODE_RR,
  parameter int LOCK = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             in_valid,
  input  logic [N*W-1:0]           in_data,
  input  logic [N-1:0]             in_last,
  output logic [N-1:0]             in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_last,
  output logic [sel_width(N)-1:0]  out_sel,
  input  logic                     out_ready
);

  localparam int SW = sel_width(N);

  logic [SW-1:0] r_ptr;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_out_last;
  logic [SW-1:0] r_out_sel;

  logic          w_load_en;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_idx;
  logic          w_xfer;
  logic          w_lock_en;
  logic [SW-1:0] w_lock_idx;
  logic          w_ptr_adv;

  assign w_load_en = ~r_out_valid | out_ready;
  assign in_ready  = w_grant & {N{w_load_en}};
  assign w_xfer    = |(in_valid & in_ready);

  rr_arbiter #(.N(N), .MODE(MODE), .SW(SW)) u_arb (
    .req       (in_valid),
    .ptr       (r_ptr),
    .lock_en   (w_lock_en),
    .lock_idx  (w_lock_idx),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= in_data[w_idx*W +: W];
        r_out_last <= in_last[w_idx];
        r_out_sel  <= w_idx;
      end
    end
  end

  // Under packet lock the pointer only moves once the whole packet has gone.
  assign w_ptr_adv = w_xfer && (MODE == MODE_RR) && ((LOCK == 0) || in_last[w_idx]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_ptr_adv) begin
      r_ptr <= (w_idx == SW'(N - 1)) ? '0 : w_idx + SW'(1);
    end
  end

  generate
    if (LOCK != 0) begin : g_lock
      lock_state_e   r_state;
      lock_state_e   w_state_nxt;
      logic [SW-1:0] r_lock_idx;
      logic [SW-1:0] w_lock_idx_nxt;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state    <= LOCK_IDLE;
          r_lock_idx <= '0;
        end else begin
          r_state    <= w_state_nxt;
          r_lock_idx <= w_lock_idx_nxt;
        end
      end

      always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        case (r_state)
          LOCK_IDLE: begin
            if (w_xfer && !in_last[w_idx]) begin
              w_state_nxt    = LOCK_HELD;
              w_lock_idx_nxt = w_idx;
            end
          end
          LOCK_HELD: begin
            if (w_xfer && in_last[w_idx]) begin
              w_state_nxt = LOCK_IDLE;
            end
          end
          default: w_state_nxt = LOCK_IDLE;
        endcase
      end

      assign w_lock_en  = (r_state == LOCK_HELD);
      assign w_lock_idx = r_lock_idx;
    end else begin : g_nolock
      assign w_lock_en  = 1'b0;
      assign w_lock_idx = '0;
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - directed self-checking bench for rr_stream_mux in RR, fixed and lock modes
module tb_rr_stream_mux;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: round-robin, no lock
  logic [N-1:0]   a_valid, a_last, a_ready;
  logic [N*W-1:0] a_data;
  logic           a_ovalid, a_olast, a_oready;
  logic [W-1:0]   a_odata;
  logic [1:0]     a_osel;

  // Instance B: fixed priority
  logic [N-1:0]   b_valid, b_last, b_ready;
  logic [N*W-1:0] b_data;
  logic           b_ovalid, b_olast, b_oready;
  logic [W-1:0]   b_odata;
  logic [1:0]     b_osel;

  // Instance C: round-robin with packet lock
  logic [N-1:0]   c_valid, c_last, c_ready;
  logic [N*W-1:0] c_data;
  logic           c_ovalid, c_olast, c_oready;
  logic [W-1:0]   c_odata;
  logic [1:0]     c_osel;

  rr_stream_mux #(.W(W), .N(N), .MODE(0), .LOCK(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
    .in_ready(a_ready), .out_valid(a_ovalid), .out_data(a_odata), .out_last(a_olast),
    .out_sel(a_osel), .out_ready(a_oready));

  rr_stream_mux #(.W(W), .N(N), .MODE(1), .LOCK(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .in_ready(b_ready), .out_valid(b_ovalid), .out_data(b_odata), .out_last(b_olast),
    .out_sel(b_osel), .out_ready(b_oready));

  rr_stream_mux #(.W(W), .N(N), .MODE(0), .LOCK(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_data(c_data), .in_last(c_last),
    .in_ready(c_ready), .out_valid(c_ovalid), .out_data(c_odata), .out_last(c_olast),
    .out_sel(c_osel), .out_ready(c_oready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_valid = '0; a_last = '0; a_data = '0; a_oready = 1'b1;
    b_valid = '0; b_last = '0; b_data = '0; b_oready = 1'b1;
    c_valid = '0; c_last = '0; c_data = '0; c_oready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, a_ovalid}, 32'd0);
    check("rst_out_data",  {24'd0, a_odata},  32'd0);
    check("rst_out_sel",   {30'd0, a_osel},   32'd0);
    check("rst_out_last",  {31'd0, a_olast},  32'd0);

    // Basic round-robin over four always-valid channels
    a_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    a_valid = 4'hF;
    #1;
    check("rr_first_ready", {28'd0, a_ready}, 32'h1);
    check("rr_no_early_valid", {31'd0, a_ovalid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_valid", {31'd0, a_ovalid}, 32'd1);
      check("rr_sel",   {30'd0, a_osel},   32'(k % 4));
      check("rr_data",  {24'd0, a_odata},  32'h10 + 32'(k % 4));
    end
    a_valid = '0;
    tick();
    check("drain_valid", {31'd0, a_ovalid}, 32'd0);
    check("drain_data_kept", {24'd0, a_odata}, 32'h10);

    // Wrap: ptr is 1 here; ch3 then ch0 alone, pointer should land on 1
    a_valid = 4'b1000;
    #1;
    check("wrap_ready3", {28'd0, a_ready}, 32'h8);
    tick();
    check("wrap_sel3", {30'd0, a_osel}, 32'd3);
    a_valid = 4'b0001;
    #1;
    check("wrap_ready0", {28'd0, a_ready}, 32'h1);
    tick();
    check("wrap_sel0", {30'd0, a_osel}, 32'd0);
    a_valid = '0;
    #1;
    check("idle_ready", {28'd0, a_ready}, 32'h0);
    tick();
    check("idle_valid", {31'd0, a_ovalid}, 32'd0);
    a_valid = 4'hF;
    tick();
    check("ptr_after_wrap", {30'd0, a_osel}, 32'd1);
    a_valid = '0;
    tick();

    // Backpressure on a single ch2 beat
    a_data  = {8'h00, 8'hAB, 8'h00, 8'h00};
    a_valid = 4'b0100;
    tick();
    check("bp_load", {24'd0, a_odata}, 32'hAB);
    a_oready = 1'b0;
    a_data   = {8'h00, 8'hCD, 8'h00, 8'h00};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_ready_low", {28'd0, a_ready}, 32'h0);
      check("bp_valid_held", {31'd0, a_ovalid}, 32'd1);
      check("bp_data_held", {24'd0, a_odata}, 32'hAB);
      tick();
    end
    a_oready = 1'b1;
    #1;
    check("bp_release_ready", {28'd0, a_ready}, 32'h4);
    tick();
    check("bp_next_beat", {24'd0, a_odata}, 32'hCD);
    a_valid = '0;
    tick();

    // Fixed priority: ch1 beats ch3 every cycle
    b_data  = {8'h23, 8'h22, 8'h21, 8'h20};
    b_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fix_ready", {28'd0, b_ready}, 32'h2);
      tick();
      check("fix_sel", {30'd0, b_osel}, 32'd1);
      check("fix_data", {24'd0, b_odata}, 32'h21);
    end
    b_valid = '0;

    // Lock: 3-beat ch0 packet with a gap, ch1 waiting
    c_data  = {8'h00, 8'h00, 8'h41, 8'h30};
    c_valid = 4'b0011;
    c_last  = 4'b0000;
    tick();
    check("lk_b1_sel", {30'd0, c_osel}, 32'd0);
    c_data = {8'h00, 8'h00, 8'h41, 8'h31};
    #1;
    check("lk_b2_ready", {28'd0, c_ready}, 32'h1);
    tick();
    check("lk_b2_sel", {30'd0, c_osel}, 32'd0);
    c_valid = 4'b0010;
    #1;
    check("lk_gap_ready", {28'd0, c_ready}, 32'h1);
    tick();
    check("lk_gap_drain", {31'd0, c_ovalid}, 32'd0);
    c_valid = 4'b0011;
    c_last  = 4'b0001;
    c_data  = {8'h00, 8'h00, 8'h41, 8'h32};
    #1;
    check("lk_b3_ready", {28'd0, c_ready}, 32'h1);
    tick();
    check("lk_b3_sel",  {30'd0, c_osel},  32'd0);
    check("lk_b3_data", {24'd0, c_odata}, 32'h32);
    check("lk_b3_last", {31'd0, c_olast}, 32'd1);
    c_valid = 4'b0010;
    c_last  = 4'b0010;
    #1;
    check("lk_unlock_ready", {28'd0, c_ready}, 32'h2);
    tick();
    check("lk_ch1_sel", {30'd0, c_osel}, 32'd1);

    // Reset mid-packet: ptr is 2, ch0 alone wraps in and locks
    c_data  = {8'h00, 8'h55, 8'h00, 8'h50};
    c_valid = 4'b0001;
    c_last  = 4'b0000;
    tick();
    tick();
    check("rm_b2_sel", {30'd0, c_osel}, 32'd0);
    c_valid = 4'b0100;
    #1;
    check("rm_locked_ready", {28'd0, c_ready}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rm_valid", {31'd0, c_ovalid}, 32'd0);
    check("rm_data",  {24'd0, c_odata},  32'd0);
    check("rm_sel",   {30'd0, c_osel},   32'd0);
    check("rm_last",  {31'd0, c_olast},  32'd0);
    #1;
    check("rm_ch2_ready", {28'd0, c_ready}, 32'h4);
    tick();
    check("rm_ch2_sel",  {30'd0, c_osel},  32'd2);
    check("rm_ch2_data", {24'd0, c_odata}, 32'h55);
    c_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
